// File: rtl/prefetch_fifo_pkg.sv
// Shared derivations and parameter legality checks for the prefetch pack FIFO.
// Pure elaboration-time helpers: there is no logic, latency or backpressure here.
package prefetch_fifo_pkg;

  function automatic int out_width(input int in_width, input int ratio);
    return in_width * ratio;
  endfunction

  function automatic int level_width(input int depth_width);
    return depth_width + 1;
  endfunction

  function automatic int cnt_width(input int ratio);
    return $clog2(ratio);
  endfunction

  function automatic bit params_legal(input int in_width, input int ratio, input int depth_width);
    return (in_width >= 1) && (in_width <= 256) &&
           (ratio >= 2) && (ratio <= 16) &&
           (depth_width >= 1) && (depth_width <= 10);
  endfunction

endpackage

// File: rtl/prefetch_fifo_packer.sv
// Packs RATIO sub-words LSB-first into one entry and emits a push strobe the cycle it completes.
// Only the completing sub-word stalls on full; with PREFETCH_PACK_FIFO_FLUSH_EN a flush pushes a zero-padded partial.
module prefetch_fifo_packer
  import prefetch_fifo_pkg::*;
#(
  parameter int IN_WIDTH = 16,
  parameter int RATIO = 8,
  localparam int OUT_WIDTH = out_width(IN_WIDTH, RATIO),
  localparam int CNT_WIDTH = cnt_width(RATIO)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [IN_WIDTH-1:0]  wr_data,
  output logic                 wr_vld,
  input  logic                 flush,
  input  logic                 full,
  input  logic                 pop,
  output logic                 push,
  output logic [OUT_WIDTH-1:0] push_entry
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(RATIO - 1);

  logic [CNT_WIDTH-1:0] pack_cnt;
  logic [OUT_WIDTH-1:0] pack_buf;
  logic [OUT_WIDTH-1:0] buf_next;
  logic                 flush_pend;
  logic                 flush_push;
  logic                 last;
  logic                 accept;
  logic                 completing;

  assign last       = pack_cnt == CNT_LAST;
  assign wr_vld     = !(full && last) && !flush_pend;
  assign accept     = wr_en && wr_vld;
  assign completing = accept && last;

  always_comb begin
    buf_next = pack_buf;
    for (int k = 0; k < RATIO; k++) begin
      if (accept && (pack_cnt == CNT_WIDTH'(k))) begin
        buf_next[k*IN_WIDTH +: IN_WIDTH] = wr_data;
      end
    end
  end

`ifdef PREFETCH_PACK_FIFO_FLUSH_EN
  logic has_data;
  logic flush_req;

  assign has_data  = (pack_cnt != '0) || accept;
  assign flush_req = (flush || flush_pend) && has_data && !completing;
  // A pop this cycle frees a slot, so a pending flush may push alongside it.
  assign flush_push = flush_req && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_pend <= 1'b0;
    end else begin
      flush_pend <= flush_req && full && !pop;
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = flush | pop;
  assign flush_pend    = 1'b0;
  assign flush_push    = 1'b0;
`endif

  assign push       = completing || flush_push;
  assign push_entry = buf_next;

  // The buffer is cleared on every push so unfilled upper lanes are always zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_cnt <= '0;
      pack_buf <= '0;
    end else if (push) begin
      pack_cnt <= '0;
      pack_buf <= '0;
    end else if (accept) begin
      pack_cnt <= pack_cnt + 1'b1;
      pack_buf <= buf_next;
    end
  end

endmodule

// File: rtl/prefetch_pack_fifo.sv
// Width-upsizing FWFT FIFO: a completed entry is visible on rd_data one cycle after its last sub-word.
// Write stalls only for the completing sub-word while full; PREFETCH_PACK_FIFO_FLUSH_EN enables partial flush.
module prefetch_pack_fifo
  import prefetch_fifo_pkg::*;
#(
  parameter int IN_WIDTH = 16,
  parameter int RATIO = 8,
  parameter int DEPTH_WIDTH = 4,
  localparam int OUT_WIDTH = out_width(IN_WIDTH, RATIO),
  localparam int LVL_WIDTH = level_width(DEPTH_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [IN_WIDTH-1:0]  wr_data,
  output logic                 wr_vld,
  input  logic                 flush,
  input  logic                 rd_en,
  output logic                 rd_vld,
  output logic [OUT_WIDTH-1:0] rd_data,
  output logic [LVL_WIDTH-1:0] rd_level
);

  localparam int DEPTH = 2 ** DEPTH_WIDTH;

  if (!params_legal(IN_WIDTH, RATIO, DEPTH_WIDTH)) begin : g_bad_params
    $error("prefetch_pack_fifo: illegal IN_WIDTH/RATIO/DEPTH_WIDTH");
  end

  logic [OUT_WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH_WIDTH-1:0] wr_ptr;
  logic [DEPTH_WIDTH-1:0] rd_ptr;
  logic [LVL_WIDTH-1:0]   level;
  logic                   full;
  logic                   pop;
  logic                   push;
  logic [OUT_WIDTH-1:0]   push_entry;

  assign full     = level == LVL_WIDTH'(DEPTH);
  assign rd_vld   = level != '0;
  assign pop      = rd_en && rd_vld;
  assign rd_data  = mem[rd_ptr];
  assign rd_level = level;

  prefetch_fifo_packer #(
    .IN_WIDTH(IN_WIDTH),
    .RATIO   (RATIO)
  ) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_vld    (wr_vld),
    .flush     (flush),
    .full      (full),
    .pop       (pop),
    .push      (push),
    .push_entry(push_entry)
  );

  // Storage is cleared on reset so rd_data reads zero until the first push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_prefetch_pack_fifo.sv
// Randomised and directed bench for prefetch_pack_fifo against a queue-based reference model.
module tb_prefetch_pack_fifo;

  localparam int IW    = 16;
  localparam int R     = 8;
  localparam int DW    = 4;
  localparam int OW    = IW * R;
  localparam int DEPTH = 2 ** DW;
  localparam int LW    = DW + 1;
`ifdef PREFETCH_PACK_FIFO_FLUSH_EN
  localparam bit FLUSH_ON = 1'b1;
`else
  localparam bit FLUSH_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [IW-1:0] wr_data;
  logic          wr_vld;
  logic          flush;
  logic          rd_en;
  logic          rd_vld;
  logic [OW-1:0] rd_data;
  logic [LW-1:0] rd_level;

  prefetch_pack_fifo #(
    .IN_WIDTH   (IW),
    .RATIO      (R),
    .DEPTH_WIDTH(DW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .wr_vld  (wr_vld),
    .flush   (flush),
    .rd_en   (rd_en),
    .rd_vld  (rd_vld),
    .rd_data (rd_data),
    .rd_level(rd_level)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: stored entries as a queue, pending sub-words as a list.
  logic [OW-1:0] mq[$];
  logic [IW-1:0] lanes[$];
  bit            pend;

  task automatic chk(input string tag, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [OW-1:0] pack_lanes();
    logic [OW-1:0] e = '0;
    foreach (lanes[k]) e[k*IW +: IW] = lanes[k];
    return e;
  endfunction

  function automatic bit exp_wr_vld();
    return !((mq.size() == DEPTH) && (lanes.size() == R - 1)) && !pend;
  endfunction

  task automatic model_reset();
    mq.delete();
    lanes.delete();
    pend = 1'b0;
  endtask

  task automatic model_step(input logic we, input logic [IW-1:0] d, input logic fl, input logic re);
    bit full_now, acc, pop_now, room;
    full_now = mq.size() == DEPTH;
    acc      = we && exp_wr_vld();
    pop_now  = re && (mq.size() != 0);
    room     = !full_now || pop_now;
    if (pop_now) void'(mq.pop_front());
    if (acc) lanes.push_back(d);
    if (lanes.size() == R) begin
      mq.push_back(pack_lanes());
      lanes.delete();
    end else if (FLUSH_ON && (fl || pend) && (lanes.size() != 0)) begin
      if (room) begin
        mq.push_back(pack_lanes());
        lanes.delete();
        pend = 1'b0;
      end else begin
        pend = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    chk("wr_vld", wr_vld, exp_wr_vld());
    chk("rd_vld", rd_vld, mq.size() != 0);
    chk("rd_level", rd_level, mq.size());
    if (mq.size() != 0) chk("rd_data", rd_data, mq[0]);
  endtask

  task automatic tick(input logic we, input logic [IW-1:0] d, input logic fl, input logic re);
    wr_en   = we;
    wr_data = d;
    flush   = fl;
    rd_en   = re;
    @(posedge clk);
    model_step(we, d, fl, re);
    #1;
    check_outputs();
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && mq.size() != 0; i++) tick(1'b0, '0, 1'b0, 1'b1);
    chk("drain_empty", rd_level, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [OW-1:0] e0;
    logic [OW-1:0] exp_e;
    logic [IW-1:0] d;
    int            maxlvl;

    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; flush = 1'b0; rd_en = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_vld", wr_vld, 1);
    chk("rst_rd_vld", rd_vld, 0);
    chk("rst_level", rd_level, 0);
    chk("rst_rd_data", rd_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sub-words 1..16 give two entries, first-written in the LSBs.
    e0 = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
    for (int i = 1; i <= 8; i++) tick(1'b1, IW'(i), 1'b0, 1'b0);
    chk("first_entry_vld", rd_vld, 1);
    chk("first_entry_data", rd_data, e0);
    for (int i = 9; i <= 16; i++) tick(1'b1, IW'(i), 1'b0, 1'b0);
    chk("two_entries_level", rd_level, 2);

    // Fill to full, then partial-pack while full until the completing sub-word stalls.
    for (int i = 17; i <= 128; i++) tick(1'b1, IW'(i), 1'b0, 1'b0);
    chk("full_level", rd_level, 16);
    for (int i = 0; i < 7; i++) tick(1'b1, IW'($urandom), 1'b0, 1'b0);
    chk("stall_wr_vld", wr_vld, 0);
    repeat (10) tick(1'b1, IW'($urandom), 1'b0, 1'b0);
    chk("stall_level", rd_level, 16);
    tick(1'b0, '0, 1'b0, 1'b1);
    chk("pop_frees_wr_vld", wr_vld, 1);
    chk("pop_level", rd_level, 15);
    tick(1'b1, 16'h5a5a, 1'b0, 1'b0);
    chk("refill_level", rd_level, 16);
    drain(40);

    repeat (10) tick(1'b0, '0, 1'b0, 1'b1);
    chk("empty_rd_vld", rd_vld, 0);
    chk("empty_level", rd_level, 0);

    tick(1'b1, 16'haaaa, 1'b0, 1'b0);
    tick(1'b1, 16'hbbbb, 1'b0, 1'b0);
    tick(1'b1, 16'hcccc, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b1, 1'b0);
`ifdef PREFETCH_PACK_FIFO_FLUSH_EN
    exp_e = '0;
    exp_e[47:0] = 48'hcccc_bbbb_aaaa;
    chk("flush_entry", rd_data, exp_e);
    chk("flush_level", rd_level, 1);
    drain(4);
    // Flush while full must wait for a pop.
    for (int i = 0; i < 128; i++) tick(1'b1, IW'($urandom), 1'b0, 1'b0);
    tick(1'b1, 16'h1234, 1'b0, 1'b0);
    tick(1'b1, 16'h5678, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b1, 1'b0);
    chk("flush_pend_wr_vld", wr_vld, 0);
    chk("flush_pend_level", rd_level, 16);
    tick(1'b0, '0, 1'b0, 1'b1);
    chk("flush_pend_after_pop", rd_level, 16);
    chk("flush_pend_cleared", wr_vld, 1);
    for (int i = 0; i < 15; i++) tick(1'b0, '0, 1'b0, 1'b1);
    exp_e = '0;
    exp_e[31:0] = 32'h5678_1234;
    chk("flush_pend_entry", rd_data, exp_e);
    drain(4);
`else
    chk("flush_ignored_level", rd_level, 0);
    for (int i = 0; i < 5; i++) tick(1'b1, IW'(i + 1), 1'b0, 1'b0);
    exp_e = 128'h0005_0004_0003_0002_0001_cccc_bbbb_aaaa;
    chk("no_flush_entry", rd_data, exp_e);
    drain(4);
`endif

    // Asynchronous reset mid-pack with stored entries.
    for (int i = 0; i < 37; i++) tick(1'b1, IW'($urandom), 1'b0, 1'b0);
    chk("pre_reset_level", rd_level, 4);
    wr_en = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_reset_rd_vld", rd_vld, 0);
    chk("mid_reset_level", rd_level, 0);
    chk("mid_reset_wr_vld", wr_vld, 1);
    chk("mid_reset_rd_data", rd_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) tick(1'b1, IW'(16'h0100 + i), 1'b0, 1'b0);
    chk("post_reset_entry", rd_data, 128'h0107_0106_0105_0104_0103_0102_0101_0100);
    chk("post_reset_level", rd_level, 1);
    drain(4);

    // Streaming: one entry per 8 cycles in, read enabled continuously.
    maxlvl = 0;
    for (int e = 0; e < 1000; e++) begin
      for (int k = 0; k < R; k++) begin
        tick(1'b1, IW'($urandom), 1'b0, 1'b1);
        if (int'(rd_level) > maxlvl) maxlvl = int'(rd_level);
      end
    end
    chk("stream_max_level", maxlvl, 1);

    // Random traffic, biased first towards filling then towards draining.
    for (int i = 0; i < 3000; i++) begin
      d = IW'($urandom);
      tick(($urandom_range(0, 3) != 0), d, ($urandom_range(0, 19) == 0),
           (i < 1500) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7));
    end
    drain(40);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
